// File: rtl/jtag_pkg.sv
// Shared JTAG definitions for the TAP block and its data-register helpers.
//
// Contents:
//   IDCODE         - 32-bit device identification word shifted out on IDCODE.
//   DEFAULT_WIDTH  - default serializer width (one IDCODE word).
//   tap_state_t    - TAP controller state encodings (IEEE 1149.1 state names).
//   IR_*           - instruction register opcodes decoded by the TAP.
package jtag_pkg;

    localparam logic [31:0] IDCODE        = 32'h000F_AF01;
    localparam int          DEFAULT_WIDTH = 32;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR_SCAN   = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR_SCAN   = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_state_t;

    localparam logic [3:0] IR_IDCODE = 4'b1110;
    localparam logic [3:0] IR_BYPASS = 4'b1111;
    localparam logic [3:0] IR_ABORT  = 4'b1000;

endpackage

// File: rtl/jtag_byte_transmitter_mux_2_1.sv
// Two-input single-bit multiplexer used to pick the TDO source.
//
// Ports:
//   one      in  1 - selected when selector is 1
//   two      in  1 - selected when selector is 0
//   selector in  1 - select line
//   out      out 1 - selector ? one : two (combinational)
module mux_2_1 (
    input  logic one,
    input  logic two,
    input  logic selector,
    output logic out
);

    assign out = selector ? one : two;

endmodule

// File: rtl/jtag_byte_transmitter.sv
// LSB-first serializer for a WIDTH-bit word (the IDCODE on the Shift-DR
// path), one bit per enabled TCK edge, with a completion flag and a TDO
// mux that can substitute an alternate bit from the TAP controller.
//
// Parameters:
//   WIDTH    - bits serialized per word (default 32)
// Ports:
//   clk      in  1     - TCK, all state on posedge
//   reset_n  in  1     - synchronous active-low reset, wins over enable
//   enable   in  1     - advance one bit this cycle
//   in       in  WIDTH - word, captured on the first enabled edge after reset
//   tap_in   in  1     - alternate bit from the TAP controller
//   sel      in  1     - 1 = tdo from tap_in, 0 = tdo from serializer
//   out      out 1     - registered serializer bit
//   done     out 1     - registered, high once the last bit is on out
//   tdo      out 1     - combinational sel ? tap_in : out
//
// Build option:
//   JTAG_BYTE_TRANSMITTER_FORMAL_EN - compiles in embedded assertions and a
//   cover point; without it no checking logic exists.
import jtag_pkg::*;

module jtag_byte_transmitter #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    input  logic             tap_in,
    input  logic             sel,
    output logic             out,
    output logic             done,
    output logic             tdo
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift;
    logic [CW-1:0]    count;

    // count is the number of bits already placed on out; it saturates at
    // WIDTH so a finished word stays finished until the next reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift <= '0;
            count <= '0;
            out   <= 1'b0;
            done  <= 1'b0;
        end else if (enable) begin
            if (count == '0) begin
                // Capture edge: bit 0 goes straight out, the rest is stored.
                out   <= in[0];
                shift <= in >> 1;
                count <= CW'(1);
                if (WIDTH == 1) begin
                    done <= 1'b1;
                end
            end else if (count < FULL) begin
                out   <= shift[0];
                shift <= shift >> 1;
                count <= count + CW'(1);
                if (count == LAST) begin
                    done <= 1'b1;
                end
            end else begin
                // Overrun past the end of the word drives zeros.
                out <= 1'b0;
            end
        end
    end

    mux_2_1 u_tdo_mux (
        .one      (tap_in),
        .two      (out),
        .selector (sel),
        .out      (tdo)
    );

`ifdef JTAG_BYTE_TRANSMITTER_FORMAL_EN
    a_reset_state : assert property (@(posedge clk)
        !reset_n |=> (out == 1'b0 && done == 1'b0 && count == '0));
    a_count_range : assert property (@(posedge clk) count <= FULL);
    a_done_count  : assert property (@(posedge clk) done |-> count == FULL);
    a_busy_clear  : assert property (@(posedge clk) (count < FULL) |-> !done);
    a_tdo_tap     : assert property (@(posedge clk) sel |-> tdo == tap_in);
    c_done_rise   : cover property (@(posedge clk) $rose(done));
`else
`endif

endmodule

// File: tb/tb_jtag_byte_transmitter.sv
// Self-checking bench for jtag_byte_transmitter: directed scenarios from the
// test plan plus a randomized run, all compared against a word/bit-index
// reference model and a fixed expected IDCODE bit sequence.
module tb_jtag_byte_transmitter;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic [W-1:0] in;
    logic         tap_in;
    logic         sel;
    logic         out;
    logic         done;
    logic         tdo;

    always #5 clk = ~clk;

    jtag_byte_transmitter #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .in      (in),
        .tap_in  (tap_in),
        .sel     (sel),
        .out     (out),
        .done    (done),
        .tdo     (tdo)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [0:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the captured word and how many of its bits have
    // been emitted so far.
    logic [W-1:0] m_word;
    int           m_k;
    logic         m_out;
    logic         m_done;

    task automatic model_edge(input logic r, input logic en, input logic [W-1:0] d);
        if (!r) begin
            m_k = 0; m_out = 1'b0; m_done = 1'b0; m_word = '0;
        end else if (en) begin
            if (m_k == 0) m_word = d;
            if (m_k < W) begin
                m_out  = m_word[m_k];
                m_k    = m_k + 1;
                m_done = (m_k == W);
            end else begin
                m_out = 1'b0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: inputs already set by the caller are what the DUT samples.
    task automatic tick(input string tag);
        logic         r  = reset_n;
        logic         en = enable;
        logic [W-1:0] d  = in;
        @(posedge clk);
        model_edge(r, en, d);
        #1;
        check_eq({tag, "_out"},  {31'd0, out},  {31'd0, m_out});
        check_eq({tag, "_done"}, {31'd0, done}, {31'd0, m_done});
        check_eq({tag, "_tdo"},  {31'd0, tdo},  {31'd0, (sel ? tap_in : m_out)});
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        repeat (cycles) tick("rst");
        reset_n = 1'b1;
    endtask

    int idcode_bits[32] = '{1,0,0,0, 0,0,0,0, 1,1,1,1, 0,1,0,1,
                            1,1,1,1, 0,0,0,0, 0,0,0,0, 0,0,0,0};

    initial begin
        reset_n = 1'b0; enable = 1'b0; in = '0; tap_in = 1'b0; sel = 1'b1;
        m_word = '0; m_k = 0; m_out = 1'b0; m_done = 1'b0;
        #1;

        // Reset, then idle
        do_reset(2);
        check_eq("reset_out",  {31'd0, out},  32'd0);
        check_eq("reset_done", {31'd0, done}, 32'd0);
        check_eq("reset_tdo",  {31'd0, tdo},  32'd0);

        // IDCODE shift checked against the fixed expected bit table
        sel = 1'b0; in = 32'h000F_AF01; enable = 1'b1;
        foreach (idcode_bits[i]) exp_q.push_back(1'(idcode_bits[i]));
        for (int i = 0; i < W; i++) begin
            logic b;
            tick("idcode");
            b = exp_q.pop_front();
            check_eq($sformatf("idcode_bit%0d", i), {31'd0, tdo}, {31'd0, b});
            check_eq($sformatf("idcode_done%0d", i), {31'd0, done},
                     (i == W - 1) ? 32'd1 : 32'd0);
            in = $urandom();   // must be ignored after capture
        end

        // Overrun: three more enabled cycles
        for (int i = 0; i < 3; i++) begin
            tick("overrun");
            check_eq("overrun_out",  {31'd0, out},  32'd0);
            check_eq("overrun_done", {31'd0, done}, 32'd1);
        end

        // Pause after bit 7, resume gives bit 8 (=1)
        enable = 1'b0;
        do_reset(1);
        in = 32'h000F_AF01; enable = 1'b1;
        repeat (8) tick("pre_pause");
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick("pause");
            check_eq("pause_out",  {31'd0, out},  32'd0);
            check_eq("pause_done", {31'd0, done}, 32'd0);
        end
        enable = 1'b1;
        tick("resume");
        check_eq("resume_bit8", {31'd0, out}, 32'd1);

        // Continue to bit 10, then reset mid-word with enable still high
        repeat (2) tick("to_bit10");
        reset_n = 1'b0;
        tick("mid_rst");
        check_eq("mid_rst_out",  {31'd0, out},  32'd0);
        check_eq("mid_rst_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1; in = 32'h0000_0002;
        tick("recap0");
        check_eq("recap_bit0", {31'd0, out}, 32'd0);
        in = 32'hFFFF_FFFF;
        tick("recap1");
        check_eq("recap_bit1", {31'd0, out}, 32'd1);
        check_eq("recap_done", {31'd0, done}, 32'd0);

        // Mux: tdo follows tap_in within the same cycle
        sel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tap_in = i[0];
            #1;
            check_eq("mux_comb", {31'd0, tdo}, {31'd0, i[0]});
            tick("mux_run");
        end

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 60) != 0);
            enable  = ($urandom_range(0, 3) != 0);
            in      = $urandom();
            sel     = 1'($urandom_range(0, 1));
            tap_in  = 1'($urandom_range(0, 1));
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
